// File: rtl/uart_baud_ctrl_pkg.sv
// rtl/uart_baud_ctrl_pkg.sv - shared constants, k table and FSM encoding for the baud controller
package uart_pkg;

  localparam logic [3:0] BAUD_CODE_MAX = 4'd11;
  localparam logic [3:0] BAUD_RESET    = 4'd8;
  localparam int         CNT_W         = 19;

  // Bit time in 100 MHz clocks for each valid baud select code
  localparam logic [CNT_W-1:0] K_0  = 19'd333333;
  localparam logic [CNT_W-1:0] K_1  = 19'd83333;
  localparam logic [CNT_W-1:0] K_2  = 19'd41667;
  localparam logic [CNT_W-1:0] K_3  = 19'd20833;
  localparam logic [CNT_W-1:0] K_4  = 19'd10417;
  localparam logic [CNT_W-1:0] K_5  = 19'd5208;
  localparam logic [CNT_W-1:0] K_6  = 19'd2604;
  localparam logic [CNT_W-1:0] K_7  = 19'd1736;
  localparam logic [CNT_W-1:0] K_8  = 19'd868;
  localparam logic [CNT_W-1:0] K_9  = 19'd434;
  localparam logic [CNT_W-1:0] K_10 = 19'd217;
  localparam logic [CNT_W-1:0] K_11 = 19'd109;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  function automatic logic baud_code_ok(input logic [3:0] code);
    return code <= BAUD_CODE_MAX;
  endfunction

endpackage

// File: rtl/uart_baud_ctrl_if.sv
// rtl/uart_baud_ctrl_if.sv - CPU/engine-facing signal bundle of the baud controller
interface uart_baud_ctrl_if;
  import uart_pkg::*;

  logic             baud_wr;
  logic [3:0]       baud_in;
  logic             tx_busy;
  logic             rx_busy;
  logic [3:0]       baud_sel;
  logic [CNT_W-1:0] k;
  logic             tx_btu;
  logic             rx_btu;
  logic             pend;
  logic             cfg_done;
  logic             cfg_err;

  // Driven by the CPU and the TX/RX engines
  modport master (
    output baud_wr, baud_in, tx_busy, rx_busy,
    input  baud_sel, k, tx_btu, rx_btu, pend, cfg_done, cfg_err
  );

  // Implemented by uart_baud_ctrl
  modport slave (
    input  baud_wr, baud_in, tx_busy, rx_busy,
    output baud_sel, k, tx_btu, rx_btu, pend, cfg_done, cfg_err
  );

endinterface

// File: rtl/uart_baud_ctrl_k_lut.sv
// rtl/uart_baud_ctrl_k_lut.sv - baud select to bit-time (clocks) lookup
module baud_k_lut
  import uart_pkg::*;
(
  input  logic [3:0]       sel,
  output logic [CNT_W-1:0] k
);

  // Pure decode; codes above BAUD_CODE_MAX are never committed so they map to 0
  always_comb begin
    k = '0;
    case (sel)
      4'd0:    k = K_0;
      4'd1:    k = K_1;
      4'd2:    k = K_2;
      4'd3:    k = K_3;
      4'd4:    k = K_4;
      4'd5:    k = K_5;
      4'd6:    k = K_6;
      4'd7:    k = K_7;
      4'd8:    k = K_8;
      4'd9:    k = K_9;
      4'd10:   k = K_10;
      4'd11:   k = K_11;
      default: k = '0;
    endcase
  end

endmodule

// File: rtl/uart_baud_ctrl.sv
// rtl/uart_baud_ctrl.sv - baud select holder with idle-deferred commit and TX/RX bit-time counters
module uart_baud_ctrl
  import uart_pkg::*;
#(
  parameter logic [3:0] RESET_BAUD = 4'd8,
  parameter int         CNT_W      = 19
) (
  input  logic              clk,
  input  logic              reset,
  uart_baud_ctrl_if.slave   bus
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state, state_nxt;
  logic [3:0]       pend_sel, pend_sel_nxt;
  logic [3:0]       baud_sel, baud_sel_nxt;
  logic             cfg_done, cfg_done_nxt;
  logic             cfg_err;
  logic             wr_ok;
  logic             engines_idle;
  logic [CNT_W-1:0] k;
  logic [CNT_W-1:0] tx_cnt;
  logic [CNT_W-1:0] rx_cnt;
  logic [CNT_W-1:0] rx_term;
  logic             rx_first;
  logic             tx_btu;
  logic             rx_btu;

  baud_k_lut u_k_lut (
    .sel (baud_sel),
    .k   (k)
  );

  assign wr_ok        = bus.baud_wr && baud_code_ok(bus.baud_in);
  assign engines_idle = !bus.tx_busy && !bus.rx_busy;

  // Register the configuration FSM and the active/pending selects
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pend_sel <= RESET_BAUD;
      baud_sel <= RESET_BAUD;
      cfg_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      pend_sel <= pend_sel_nxt;
      baud_sel <= baud_sel_nxt;
      cfg_done <= cfg_done_nxt;
    end
  end

  // Commit the older pending select when both engines are idle; a write in the same cycle re-arms PEND
  always_comb begin
    state_nxt    = state;
    pend_sel_nxt = pend_sel;
    baud_sel_nxt = baud_sel;
    cfg_done_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (wr_ok) begin
          pend_sel_nxt = bus.baud_in;
          state_nxt    = PEND;
        end
      end
      PEND: begin
        if (engines_idle) begin
          baud_sel_nxt = pend_sel;
          cfg_done_nxt = 1'b1;
          state_nxt    = IDLE;
        end
        if (wr_ok) begin
          pend_sel_nxt = bus.baud_in;
          state_nxt    = PEND;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Flag a rejected write one cycle later without disturbing any pending change
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= bus.baud_wr && !baud_code_ok(bus.baud_in);
    end
  end

  assign tx_btu  = bus.tx_busy && (tx_cnt == (k - ONE));
  assign rx_term = rx_first ? ((k >> 1) - ONE) : (k - ONE);
  assign rx_btu  = bus.rx_busy && (rx_cnt == rx_term);

  // TX bit-time counter: runs 0..k-1 while busy, parked at 0 otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_cnt <= '0;
    end else if (!bus.tx_busy || tx_btu) begin
      tx_cnt <= '0;
    end else begin
      tx_cnt <= tx_cnt + ONE;
    end
  end

  // RX bit-time counter: first period is half a bit so sampling lands mid-bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_cnt <= '0;
    end else if (!bus.rx_busy || rx_btu) begin
      rx_cnt <= '0;
    end else begin
      rx_cnt <= rx_cnt + ONE;
    end
  end

  // Half-bit marker: armed whenever RX is idle, dropped after the first pulse of a frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_first <= 1'b1;
    end else if (!bus.rx_busy) begin
      rx_first <= 1'b1;
    end else if (rx_btu) begin
      rx_first <= 1'b0;
    end
  end

  assign bus.baud_sel = baud_sel;
  assign bus.k        = k;
  assign bus.tx_btu   = tx_btu;
  assign bus.rx_btu   = rx_btu;
  assign bus.pend     = (state == PEND);
  assign bus.cfg_done = cfg_done;
  assign bus.cfg_err  = cfg_err;

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// tb/tb_uart_baud_ctrl.sv - self-checking bench for uart_baud_ctrl against a cycle-age reference model
module tb_uart_baud_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;

  uart_baud_ctrl_if bus ();

  uart_baud_ctrl #(
    .RESET_BAUD (4'd8),
    .CNT_W      (19)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  int ktab [16] = '{333333, 83333, 41667, 20833, 10417, 5208, 2604, 1736,
                    868, 434, 217, 109, 0, 0, 0, 0};

  // Reference model: selects plus how many cycles each busy line has been high
  int m_sel, m_pval;
  bit m_pend, m_done, m_err;
  int tx_age, rx_age;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sel  = 8;
    m_pval = 8;
    m_pend = 0;
    m_done = 0;
    m_err  = 0;
    tx_age = 0;
    rx_age = 0;
  endtask

  // One clock: check every output mid-cycle, then advance the model to the next cycle
  task automatic cycle();
    int  kk, h;
    bit  tx_exp, rx_exp, commit, valid;
    @(negedge clk);
    kk     = ktab[m_sel];
    h      = kk / 2;
    tx_exp = bus.tx_busy && (((tx_age + 1) % kk) == 0);
    rx_exp = bus.rx_busy && ((rx_age + 1) >= h) && (((rx_age + 1 - h) % kk) == 0);
    chk("baud_sel", 32'(bus.baud_sel), 32'(m_sel));
    chk("k",        32'(bus.k),        32'(kk));
    chk("pend",     32'(bus.pend),     32'(m_pend));
    chk("cfg_done", 32'(bus.cfg_done), 32'(m_done));
    chk("cfg_err",  32'(bus.cfg_err),  32'(m_err));
    chk("tx_btu",   32'(bus.tx_btu),   32'(tx_exp));
    chk("rx_btu",   32'(bus.rx_btu),   32'(rx_exp));
    valid  = bus.baud_wr && (bus.baud_in <= 4'd11);
    commit = m_pend && !bus.tx_busy && !bus.rx_busy;
    m_done = commit;
    if (commit) m_sel = m_pval;
    m_pend = valid || (m_pend && !commit);
    if (valid) m_pval = int'(bus.baud_in);
    m_err  = bus.baud_wr && (bus.baud_in > 4'd11);
    tx_age = bus.tx_busy ? tx_age + 1 : 0;
    rx_age = bus.rx_busy ? rx_age + 1 : 0;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic write(input logic [3:0] code);
    bus.baud_wr = 1'b1;
    bus.baud_in = code;
    cycle();
    bus.baud_wr = 1'b0;
    bus.baud_in = 4'd0;
  endtask

  initial begin
    bus.baud_wr = 1'b0;
    bus.baud_in = 4'd0;
    bus.tx_busy = 1'b0;
    bus.rx_busy = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state, then default 868-clock TX bit time
    run(5);
    bus.tx_busy = 1'b1;
    run(870);
    bus.tx_busy = 1'b0;
    run(2);

    // Commit to the fastest rate while idle, then TX spacing of 109
    write(4'd11);
    run(3);
    bus.tx_busy = 1'b1;
    run(330);
    bus.tx_busy = 1'b0;
    run(2);

    // RX half-bit first period, and again after a re-raise
    bus.rx_busy = 1'b1;
    run(275);
    bus.rx_busy = 1'b0;
    run(2);
    bus.rx_busy = 1'b1;
    run(60);
    bus.rx_busy = 1'b0;
    run(2);

    // Writes while busy are deferred; last write wins
    bus.tx_busy = 1'b1;
    run(10);
    write(4'd5);
    run(20);
    write(4'd3);
    run(200);
    bus.tx_busy = 1'b0;
    run(4);

    // Invalid write while a change is pending does not disturb it
    bus.tx_busy = 1'b1;
    write(4'd4);
    run(3);
    write(4'd13);
    run(5);
    bus.tx_busy = 1'b0;
    run(4);

    // Commit and a new valid write in the same cycle
    bus.rx_busy = 1'b1;
    write(4'd10);
    bus.rx_busy = 1'b0;
    write(4'd11);
    run(4);

    // Async reset mid count with a pending change
    bus.tx_busy = 1'b1;
    write(4'd9);
    run(50);
    reset = 1'b1;
    bus.tx_busy = 1'b0;
    #2;
    chk("rst_baud_sel", 32'(bus.baud_sel), 32'd8);
    chk("rst_k",        32'(bus.k),        32'd868);
    chk("rst_pend",     32'(bus.pend),     32'd0);
    chk("rst_tx_btu",   32'(bus.tx_btu),   32'd0);
    chk("rst_rx_btu",   32'(bus.rx_btu),   32'd0);
    chk("rst_cfg_done", 32'(bus.cfg_done), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    run(3);

    // Randomized traffic: short-k codes plus invalid ones, random busy windows
    write(4'd11);
    run(2);
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 299) == 0) bus.tx_busy = !bus.tx_busy;
      if ($urandom_range(0, 249) == 0) bus.rx_busy = !bus.rx_busy;
      bus.baud_wr = ($urandom_range(0, 39) == 0);
      bus.baud_in = 4'($urandom_range(9, 15));
      cycle();
    end
    bus.baud_wr = 1'b0;
    bus.tx_busy = 1'b0;
    bus.rx_busy = 1'b0;
    run(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
